seg_scan_display: RTL and testbench

Parametrised multiplexed seven-segment display driver for the Nexys3 board. It accepts a binary value through a load strobe and converts it to BCD with a sequential double-dabble engine, or passes it through as hex digits. It then scans DIGITS common-anode digits at a programmable refresh rate, with leading-zero blanking, per-digit decimal points and an overflow indication. It sits between application logic that produces numbers and the board's seg/an pins.

---
 rtl/seg_scan_display.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: captures a binary value, converts it with a
// sequential double-dabble engine (or takes hex nibbles), then scans the digits.
module seg_scan_display #(
    parameter int DIGITS      = 4,
    parameter int IN_WIDTH    = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                myclk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] value,
    input  logic                load,
    input  logic                hex_mode,
    input  logic                blank_lz,
    input  logic [DIGITS-1:0]   dp,
    output logic                busy,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   an
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int EXT_W = (IN_WIDTH > BCD_W) ? IN_WIDTH : BCD_W;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PS_W  = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [BCD_W-1:0]    bcd_p0;
    logic [IN_WIDTH-1:0] bin_p0;
    logic                ovf_p0;
    logic [BCD_W-1:0]    bcd_adj;
    logic [EXT_W-1:0]    val_ext;
    logic                hex_ovf;
    logic [BCD_W-1:0]    disp_p1, disp_nxt;
    logic                ovf_p1, ovf_nxt;
    logic [PS_W-1:0]     ps;
    logic                ps_tc;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [3:0]          nib_sel;
    logic                dp_sel;
    logic                blank_sel;
    logic [7:0]          seg_d;
    logic [DIGITS-1:0]   an_d;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < DIGITS; d++)
            if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // A digit is a leading zero when it and every more significant nibble are zero.
    function automatic logic lead_zero(input logic [BCD_W-1:0] nib, input logic [IDX_W-1:0] sel);
        logic z;
        z = 1'b1;
        for (int d = 0; d < DIGITS; d++)
            if (d >= int'(sel) && nib[4*d +: 4] != 4'd0) z = 1'b0;
        return z && (sel != '0);
    endfunction

    assign val_ext = EXT_W'(value);
    generate
        if (EXT_W > BCD_W) begin : g_hex_hi
            assign hex_ovf = |val_ext[EXT_W-1:BCD_W];
        end else begin : g_hex_fit
            assign hex_ovf = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = hex_mode ? COMMIT : CONV;
            CONV:    if (cnt == CNT_W'(IN_WIDTH - 1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign bcd_adj = dabble_adjust(bcd_p0);

    always_ff @(posedge myclk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) cnt <= '0;
            else if (state == CONV) cnt <= cnt + 1'b1;
        end
    end

    // p0: conversion working registers
    always_ff @(posedge myclk) begin
        if (state == IDLE && load) begin
            if (hex_mode) begin
                bcd_p0 <= val_ext[BCD_W-1:0];
                ovf_p0 <= hex_ovf;
            end else begin
                bcd_p0 <= '0;
                ovf_p0 <= 1'b0;
            end
            bin_p0 <= value;
        end else if (state == CONV) begin
            bcd_p0 <= {bcd_adj[BCD_W-2:0], bin_p0[IN_WIDTH-1]};
            ovf_p0 <= ovf_p0 | bcd_adj[BCD_W-1];
            bin_p0 <= bin_p0 << 1;
        end
    end

    // p1: display register; the scan sees a same-edge commit through disp_nxt
    assign disp_nxt = (state == COMMIT) ? bcd_p0 : disp_p1;
    assign ovf_nxt  = (state == COMMIT) ? ovf_p0 : ovf_p1;

    always_ff @(posedge myclk) begin
        if (rst) begin
            disp_p1 <= '0;
            ovf_p1  <= 1'b0;
        end else begin
            disp_p1 <= disp_nxt;
            ovf_p1  <= ovf_nxt;
        end
    end

    assign ps_tc   = (ps == PS_W'(REFRESH_DIV - 1));
    assign idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;

    always_comb begin
        nib_sel = 4'd0;
        dp_sel  = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (IDX_W'(d) == idx_nxt) begin
                nib_sel = disp_nxt[4*d +: 4];
                dp_sel  = dp[d];
            end
        end
    end

    assign blank_sel = blank_lz && !ovf_nxt && lead_zero(disp_nxt, idx_nxt);
    assign seg_d     = {ovf_nxt ? 7'b1111110 : (blank_sel ? 7'b1111111 : glyph(nib_sel)), ~dp_sel};
    assign an_d      = ~(DIGITS'(1) << idx_nxt);

    // p2: scan outputs, updated only at the slot boundary
    always_ff @(posedge myclk) begin
        if (rst) begin
            ps  <= '0;
            idx <= IDX_W'(DIGITS - 1);
            seg <= 8'hFF;
            an  <= '1;
        end else begin
            ps <= ps_tc ? '0 : ps + 1'b1;
            if (ps_tc) begin
                idx <= idx_nxt;
                seg <= seg_d;
                an  <= an_d;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized bench for seg_scan_display: a digit-level model derives what each
// scan slot must show and the expected busy length of every load.
module tb_seg_scan_display;
    localparam int DIG = 4;
    localparam int INW = 14;
    localparam int RD  = 4;

    localparam logic [6:0] GLY [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic           myclk = 1'b0;
    logic           rst = 1'b1;
    logic [INW-1:0] value = '0;
    logic           load = 1'b0;
    logic           hex_mode = 1'b0;
    logic           blank_lz = 1'b0;
    logic [DIG-1:0] dp = '0;
    logic           busy;
    logic [7:0]     seg;
    logic [DIG-1:0] an;

    int total = 0;
    int bad = 0;

    int       dig_m [DIG];
    logic     ovf_m;
    logic     blank_m;
    logic [3:0] dp_m;

    seg_scan_display #(.DIGITS(DIG), .IN_WIDTH(INW), .REFRESH_DIV(RD)) dut (
        .myclk(myclk), .rst(rst), .value(value), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .dp(dp), .busy(busy), .seg(seg), .an(an)
    );

    always #5 myclk = ~myclk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_model(input int v, input logic h);
        int p;
        p = 1;
        for (int i = 0; i < DIG; i++) begin
            dig_m[i] = h ? ((v >> (4 * i)) & 15) : ((v / p) % 10);
            p = p * 10;
        end
        ovf_m = h ? (v >= 65536) : (v >= 10000);
    endtask

    function automatic logic [7:0] exp_seg(input int i);
        logic [6:0] g;
        logic       lz;
        lz = (i != 0) && blank_m && !ovf_m;
        for (int k = i; k < DIG; k++) if (dig_m[k] != 0) lz = 1'b0;
        if (ovf_m) g = 7'b1111110;
        else if (lz) g = 7'b1111111;
        else g = GLY[dig_m[i]];
        return {g, ~dp_m[i]};
    endfunction

    task automatic set_disp(input logic b, input logic [3:0] d);
        @(negedge myclk);
        blank_lz = b;
        dp = d;
        blank_m = b;
        dp_m = d;
    endtask

    task automatic do_load(input int v, input logic h, input string tag);
        int cnt;
        @(negedge myclk);
        value = INW'(v);
        hex_mode = h;
        load = 1'b1;
        @(negedge myclk);
        load = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge myclk);
        end
        chk({tag, "_busy"}, cnt, h ? 1 : INW + 1);
        set_model(v, h);
    endtask

    task automatic scan_check(input string tag);
        logic [3:0] prev;
        logic [3:0] seen;
        logic       started;
        int         run;
        int         idx;
        repeat (2 * DIG * RD) @(posedge myclk);
        @(negedge myclk);
        prev = an;
        run = 1;
        started = 1'b0;
        seen = '0;
        for (int k = 0; k < 3 * DIG * RD; k++) begin
            @(negedge myclk);
            chk({tag, "_onehot"}, $countones(~an), 1);
            if (an != prev) begin
                if (started) chk({tag, "_slotlen"}, run, RD);
                started = 1'b1;
                run = 1;
                idx = 0;
                for (int i = 0; i < DIG; i++) if (!an[i]) idx = i;
                seen[idx] = 1'b1;
                chk($sformatf("%s_d%0d", tag, idx), seg, exp_seg(idx));
                prev = an;
            end else begin
                run++;
            end
        end
        chk({tag, "_seen"}, seen, 4'hF);
    endtask

    initial begin
        int cnt;
        int v;
        logic h;
        blank_m = 1'b0;
        dp_m = '0;
        set_model(0, 1'b0);

        repeat (3) @(negedge myclk);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 4'hF);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        cnt = 0;
        do begin
            @(negedge myclk);
            cnt++;
        end while (an == 4'hF && cnt < 20);
        chk("first_lat", cnt, RD);
        chk("first_an", an, 4'hE);
        chk("first_seg", seg, 8'b0000_0011);

        set_disp(1'b0, 4'b0000);
        do_load(1234, 1'b0, "d1234");
        scan_check("d1234");
        do_load(9999, 1'b0, "d9999");
        scan_check("d9999");
        do_load(12000, 1'b0, "d12000");
        scan_check("d12000");

        set_disp(1'b1, 4'b0000);
        do_load(14'h3A5, 1'b1, "h3a5");
        scan_check("h3a5");
        set_disp(1'b1, 4'b0010);
        do_load(0, 1'b0, "zero");
        scan_check("zero");

        // second load lands mid-conversion and must be dropped
        set_disp(1'b0, 4'b0000);
        @(negedge myclk);
        value = 14'd42;
        hex_mode = 1'b0;
        load = 1'b1;
        @(negedge myclk);
        load = 1'b0;
        repeat (2) @(negedge myclk);
        value = 14'd77;
        load = 1'b1;
        @(negedge myclk);
        load = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge myclk);
        end
        chk("hs_busy", cnt, INW + 1 - 3);
        set_model(42, 1'b0);
        scan_check("hs42");

        // reset during a conversion discards it
        @(negedge myclk);
        value = 14'd555;
        load = 1'b1;
        @(negedge myclk);
        load = 1'b0;
        repeat (4) @(negedge myclk);
        rst = 1'b1;
        @(negedge myclk);
        chk("rstc_busy", busy, 0);
        chk("rstc_seg", seg, 8'hFF);
        chk("rstc_an", an, 4'hF);
        rst = 1'b0;
        set_model(0, 1'b0);
        scan_check("rstc");
        chk("rstc_idle", busy, 0);

        for (int t = 0; t < 20; t++) begin
            h = ($urandom % 4) == 0;
            case ($urandom % 3)
                0: v = $urandom_range(0, 99);
                1: v = $urandom_range(0, 9999);
                default: v = $urandom_range(0, 16383);
            endcase
            set_disp(1'($urandom % 2), 4'($urandom));
            do_load(v, h, $sformatf("r%0d", t));
            scan_check($sformatf("r%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
